// File: rtl/mult_sched_if.sv
// Requester and response bundle for mult_sched.
// The response channel carries rsp_err only when MULT_SCHED_TIMEOUT_EN is defined.
interface mult_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]    gnt;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [63:0]        rsp_prod;
`ifdef MULT_SCHED_TIMEOUT_EN
    logic               rsp_err;

    modport master (
        output req, req_a, req_b, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_prod, rsp_err
    );
    modport slave (
        input  req, req_a, req_b, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_prod, rsp_err
    );
`else
    modport master (
        output req, req_a, req_b, rsp_ready,
        input  gnt, rsp_valid, rsp_id, rsp_prod
    );
    modport slave (
        input  req, req_a, req_b, rsp_ready,
        output gnt, rsp_valid, rsp_id, rsp_prod
    );
`endif
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one sequential 32x32 multiplier among NREQ requesters.
// Optional WAIT timeout with rsp_err is enabled by defining MULT_SCHED_TIMEOUT_EN.
module mult_sched #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 200
) (
    input  logic           clk,
    input  logic           reset_n,
    mult_sched_if.slave    bus,
    output logic           mult_start,
    output logic [31:0]    mult_a,
    output logic [31:0]    mult_b,
    input  logic           mult_done,
    input  logic [63:0]    mult_prod,
    output logic           busy,
    output logic [1:0]     dbg_state,
    output logic [IDW-1:0] dbg_ptr
);
    if (IDW != $clog2(NREQ) || START_CYC < 1 || START_CYC > 15 || TIMEOUT < 1) begin : g_cfg_err
        $error("mult_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, cur_id_q, win_idx, rsp_id_q;
    logic           win_found, launch_done, armed_q;
    logic [3:0]     start_cnt_q;
    logic [31:0]    win_a, win_b;
    logic [63:0]    rsp_prod_q;
    logic           capture;
`ifdef MULT_SCHED_TIMEOUT_EN
    logic [15:0]    wait_cnt_q;
    logic           timeout_hit;
    logic           rsp_err_q;
    assign timeout_hit  = (wait_cnt_q == 16'(TIMEOUT - 1));
    assign bus.rsp_err  = rsp_err_q;
`endif

    // First requesting index at or above ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            logic [IDW-1:0] cand;
            j = int'(ptr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            cand = IDW'(j);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IDW'(i)) begin
                win_a = bus.req_a[i*32 +: 32];
                win_b = bus.req_b[i*32 +: 32];
            end
        end
    end

    // Response handshake: rsp_valid rises in RESP and holds rsp_id/rsp_prod
    // stable until a cycle with rsp_valid & rsp_ready; that edge returns to IDLE.
    always_comb begin
        state_d     = state_q;
        launch_done = (start_cnt_q == 4'(START_CYC - 1));
        capture     = mult_done && armed_q;
        bus.gnt     = '0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    bus.gnt[win_idx] = 1'b1;
                    state_d          = S_LAUNCH;
                end
            end
            S_LAUNCH: if (launch_done) state_d = S_WAIT;
`ifdef MULT_SCHED_TIMEOUT_EN
            S_WAIT: if (capture || timeout_hit) state_d = S_RESP;
`else
            S_WAIT: if (capture) state_d = S_RESP;
`endif
            S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            cur_id_q    <= '0;
            mult_a      <= '0;
            mult_b      <= '0;
            start_cnt_q <= '0;
            armed_q     <= 1'b0;
            rsp_id_q    <= '0;
            rsp_prod_q  <= '0;
`ifdef MULT_SCHED_TIMEOUT_EN
            wait_cnt_q  <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        ptr_q       <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);
                        cur_id_q    <= win_idx;
                        mult_a      <= win_a;
                        mult_b      <= win_b;
                        start_cnt_q <= '0;
                    end
                end
                S_LAUNCH: begin
                    start_cnt_q <= start_cnt_q + 4'd1;
                    if (launch_done) begin
                        armed_q <= 1'b0;
`ifdef MULT_SCHED_TIMEOUT_EN
                        wait_cnt_q <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    // A done level seen before any low cycle belongs to the previous op.
                    if (!mult_done) armed_q <= 1'b1;
`ifdef MULT_SCHED_TIMEOUT_EN
                    wait_cnt_q <= wait_cnt_q + 16'd1;
`endif
                    if (capture) begin
                        rsp_prod_q <= mult_prod;
                        rsp_id_q   <= cur_id_q;
`ifdef MULT_SCHED_TIMEOUT_EN
                        rsp_err_q  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_prod_q <= '0;
                        rsp_id_q   <= cur_id_q;
                        rsp_err_q  <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign mult_start    = (state_q == S_LAUNCH);
    assign busy          = (state_q != S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_prod  = rsp_prod_q;
    assign dbg_state     = state_q;
    assign dbg_ptr       = ptr_q;
endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: requester drivers, a behavioural multiplier unit,
// and a monitor that checks grants and responses against expected queues.
module tb_mult_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int SW   = 1 + IDW + 64;

    // Clock and reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mult_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    logic           mult_start, mult_done, busy;
    logic [31:0]    mult_a, mult_b;
    logic [63:0]    mult_prod;
    logic [1:0]     dbg_state;
    logic [IDW-1:0] dbg_ptr;

    mult_sched #(.NREQ(NREQ), .IDW(IDW), .START_CYC(2), .TIMEOUT(20)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .mult_start (mult_start),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_done  (mult_done),
        .mult_prod  (mult_prod),
        .busy       (busy),
        .dbg_state  (dbg_state),
        .dbg_ptr    (dbg_ptr)
    );

    logic        req_lv [NREQ];
    logic [31:0] a_arr  [NREQ];
    logic [31:0] b_arr  [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]           = req_lv[i];
            bus.req_a[i*32 +: 32] = a_arr[i];
            bus.req_b[i*32 +: 32] = b_arr[i];
        end
    end

    // Scoreboard state
    int tests = 0;
    int fails = 0;
    logic [SW-1:0]   exp_q[$];
    logic [NREQ-1:0] gnt_q[$];

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: expected event not seen within cycle budget", name);
    endtask

    // Behavioural shared multiplier
    int          lat = 4;
    bit          keep_done = 1'b0;
    bit          no_done = 1'b0;
    time         done_rise_t = 0;
    int          phase = 0;
    int          mcnt = 0;
    logic [31:0] ma, mb;

    initial begin
        mult_done = 1'b0;
        mult_prod = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                phase     = 0;
                mult_done = 1'b0;
            end else begin
                case (phase)
                    0: if (mult_start) begin
                        ma = mult_a;
                        mb = mult_b;
                        if (!keep_done) mult_done = 1'b0;
                        phase = 1;
                    end
                    1: if (!mult_start) begin
                        mcnt  = lat;
                        phase = 2;
                    end
                    2: if (mcnt <= 1) begin
                        mult_done = 1'b0;
                        phase     = 3;
                    end else mcnt--;
                    default: begin
                        if (!no_done) begin
                            mult_done   = 1'b1;
                            mult_prod   = {32'b0, ma} * {32'b0, mb};
                            done_rise_t = $time;
                        end
                        phase = 0;
                    end
                endcase
            end
        end
    end

    // Monitor
    logic            prev_valid = 1'b0, prev_hs = 1'b0, prev_gnt = 1'b0, prev_start = 1'b0;
    logic [IDW-1:0]  prev_id = '0;
    logic [63:0]     prev_prod = '0;
    int              start_len = 0;
    int              wait_cnt = 0;
    logic [SW-1:0]   act_rsp, exp_rsp;

    initial begin
        forever begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                if (gnt_q.size() == 0) check("gnt_unexpected", SW'(bus.gnt), '0);
                else check("gnt_order", SW'(bus.gnt), SW'(gnt_q.pop_front()));
                check("gnt_while_busy", SW'(busy), '0);
            end
            if (prev_gnt) check("gnt_to_start", SW'(mult_start), SW'(1));
            prev_gnt = (bus.gnt != '0);

            if (mult_start) start_len++;
            else if (prev_start) begin
                check("start_width", SW'(start_len), SW'(2));
                start_len = 0;
            end
            prev_start = mult_start;

            if (dbg_state == 2'd2) wait_cnt++;
            else if (dbg_state != 2'd3) wait_cnt = 0;

            if (bus.rsp_valid) begin
                if (!prev_valid) check("rsp_after_done", SW'($time > done_rise_t), SW'(1));
                else if (!prev_hs) check("rsp_stable", {1'b0, bus.rsp_id, bus.rsp_prod}, {1'b0, prev_id, prev_prod});
                if (bus.rsp_ready) begin
`ifdef MULT_SCHED_TIMEOUT_EN
                    act_rsp = {bus.rsp_err, bus.rsp_id, bus.rsp_prod};
`else
                    act_rsp = {1'b0, bus.rsp_id, bus.rsp_prod};
`endif
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rsp_unexpected: got %0h, expected no response", act_rsp);
                    end else begin
                        exp_rsp = exp_q.pop_front();
                        check("rsp_data", act_rsp, exp_rsp);
`ifdef MULT_SCHED_TIMEOUT_EN
                        if (exp_rsp[SW-1]) check("timeout_wait_cycles", SW'(wait_cnt), SW'(20));
`endif
                    end
                end
                prev_id   = bus.rsp_id;
                prev_prod = bus.rsp_prod;
            end
            prev_valid = bus.rsp_valid;
            prev_hs    = bus.rsp_valid && bus.rsp_ready;
        end
    end

    // Driver tasks
    task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] b);
        bit got = 1'b0;
        @(posedge clk);
        #1;
        a_arr[i]  = a;
        b_arr[i]  = b;
        req_lv[i] = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.gnt[i]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail($sformatf("grant_req%0d", i));
        @(posedge clk);
        #1;
        req_lv[i] = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input string name);
        bit got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (dbg_state == st) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail(name);
    endtask

    task automatic drain(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail(name);
    endtask

    initial begin
        int n;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_lv[i] = 1'b0;
            a_arr[i]  = '0;
            b_arr[i]  = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", SW'(busy), '0);
        check("rst_start", SW'(mult_start), '0);
        check("rst_valid", SW'(bus.rsp_valid), '0);
        check("rst_gnt", SW'(bus.gnt), '0);
        check("rst_ptr", SW'(dbg_ptr), '0);
        check("rst_prod", SW'(bus.rsp_prod), '0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Single request with long unit latency
        lat = 64;
        gnt_q.push_back(4'b0100);
        exp_q.push_back({1'b0, 2'd2, 64'd42});
        do_req(2, 32'h0000_0007, 32'h0000_0006);
        check("t1_mult_a", SW'(mult_a), SW'(7));
        check("t1_mult_b", SW'(mult_b), SW'(6));
        drain("t1_drain");

        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Round robin with all requests held
        lat = 4;
        gnt_q.push_back(4'b0001);
        gnt_q.push_back(4'b0010);
        gnt_q.push_back(4'b0100);
        gnt_q.push_back(4'b1000);
        gnt_q.push_back(4'b0001);
        exp_q.push_back({1'b0, 2'd0, 64'h1000});
        exp_q.push_back({1'b0, 2'd1, 64'h1100});
        exp_q.push_back({1'b0, 2'd2, 64'h1200});
        exp_q.push_back({1'b0, 2'd3, 64'h1300});
        exp_q.push_back({1'b0, 2'd0, 64'h1000});
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i]  = 32'h10 + 32'(i);
            b_arr[i]  = 32'h100;
            req_lv[i] = 1'b1;
        end
        n = 0;
        for (int k = 0; k < 2000 && n < 5; k++) begin
            @(negedge clk);
            if (bus.gnt != '0) n++;
        end
        if (n < 5) timeout_fail("t2_grants");
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) req_lv[i] = 1'b0;
        drain("t2_drain");

        // Stale done level carried over from the previous op
        keep_done = 1'b1;
        gnt_q.push_back(4'b0100);
        exp_q.push_back({1'b0, 2'd2, 64'd81});
        do_req(2, 32'd9, 32'd9);
        drain("t3_drain");
        keep_done = 1'b0;

        // Backpressure with a second requester pending
        bus.rsp_ready = 1'b0;
        gnt_q.push_back(4'b1000);
        gnt_q.push_back(4'b0001);
        exp_q.push_back({1'b0, 2'd3, 64'hFFFF_FFFE_0000_0001});
        exp_q.push_back({1'b0, 2'd0, 64'd15});
        fork
            do_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            do_req(0, 32'd3, 32'd5);
            begin
                wait_state(2'd3, "t4_resp");
                repeat (10) begin
                    @(negedge clk);
                    check("t4_no_gnt", SW'(bus.gnt), '0);
                end
                @(posedge clk);
                #1 bus.rsp_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check("t4_valid_drop", SW'(bus.rsp_valid), '0);
            end
        join
        drain("t4_drain");

        // Reset in the middle of WAIT
        lat = 30;
        gnt_q.push_back(4'b0100);
        do_req(2, 32'd2, 32'd2);
        wait_state(2'd2, "t5_wait");
        gnt_q.push_back(4'b1000);
        exp_q.push_back({1'b0, 2'd3, 64'h12340});
        fork
            do_req(3, 32'h1234, 32'h10);
            begin
                repeat (3) @(posedge clk);
                #1 reset_n = 1'b0;
                @(posedge clk);
                #1 reset_n = 1'b1;
                lat = 4;
                @(negedge clk);
                check("t5_busy", SW'(busy), '0);
                check("t5_start", SW'(mult_start), '0);
                check("t5_valid", SW'(bus.rsp_valid), '0);
                check("t5_ptr", SW'(dbg_ptr), '0);
            end
        join
        drain("t5_drain");

`ifdef MULT_SCHED_TIMEOUT_EN
        // Unit never completes, then a normal op
        no_done = 1'b1;
        gnt_q.push_back(4'b0010);
        exp_q.push_back({1'b1, 2'd1, 64'd0});
        do_req(1, 32'd5, 32'd5);
        drain("t6_timeout_drain");
        no_done = 1'b0;
        gnt_q.push_back(4'b0100);
        exp_q.push_back({1'b0, 2'd2, 64'd42});
        do_req(2, 32'd6, 32'd7);
        drain("t6_normal_drain");
`endif

        check("gnt_queue_empty", SW'(gnt_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
